mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//   Parametrised MEM pipeline stage with byte/halfword/word loads and stores.
//   Sits between the EX/MEM and MEM/WB registers and owns the MEM/WB register.
//   Routes each access to data memory, which uses a req/ack handshake, or to the
//   peripheral window, which is single-cycle. Stalls the pipeline while data
//   memory is outstanding and flags misaligned accesses.
// PARAMETERS
//   PERIPH_BASE  32'h40000000  first byte address of the peripheral window
//   PERIPH_SPAN  32'h18        window size in bytes; must be a multiple of 4
//   REG_AW       5             register write-address width
// PORTS
//   clk            in   1       clock; all state changes on the rising edge
//   rst_n          in   1       asynchronous active-low reset
//   ex_alu_out     in   32      effective address or ALU result
//   ex_rt_data     in   32      store data, before forwarding
//   ex_pc_plus_4   in   32      link value
//   ex_reg_write   in   1       instruction writes the register file
//   ex_write_addr  in   REG_AW  destination register
//   ex_mem_read    in   1       load
//   ex_mem_write   in   1       store
//   ex_mem_size    in   2       00 byte, 01 half, 10 word; 11 is treated as word
//   ex_mem_uns     in   1       load zero-extends when 1, sign-extends when 0
//   ex_mem_to_reg  in   2       00 ALU, 01 load data, 1x pc_plus_4
//   ex_forward_mem in   1       take store data from wb_out
//   stall          out  1       hold IF..EX/MEM this cycle
//   dm_req/dm_we   out  1/1     data-memory request / write strobe
//   dm_addr        out  32      word address: {ex_alu_out[31:2],2'b00}
//   dm_wdata/dm_be out  32/4    lane-replicated store data / byte enables
//   dm_rdata       in   32      read word, valid when dm_ack=1
//   dm_ack         in   1       completes the request this cycle
//   pr_re/pr_we    out  1/1     peripheral read / write strobe, combinational
//   pr_addr/pr_wdata out 32/32  peripheral address / store data
//   pr_rdata       in   32      peripheral read data, same cycle
//   wb_out         out  32      MEM/WB result register
//   wb_write_addr  out  REG_AW  MEM/WB destination register
//   wb_reg_write   out  1       MEM/WB write enable
//   misalign       out  1       registered one-cycle exception pulse
// BEHAVIOUR
// - Reset (async): wb_out=0, wb_write_addr=0, wb_reg_write=0, misalign=0, FSM=IDLE.
//   dm_req, pr_re, pr_we and stall are 0 while rst_n=0, including mid-WAIT.
// - Decode and alignment:
//   - is_per = addr in [PERIPH_BASE, PERIPH_BASE+PERIPH_SPAN); compare is unsigned, no wrap.
//   - mis = (half && addr[0]) || (word && addr[1:0]!=0).
//   - Peripheral accesses must be word-sized; otherwise mis=1.
// - Store data: sd = ex_forward_mem ? wb_out : ex_rt_data. Forwarding applies to
//   both memory and peripheral paths.
//   - Byte: wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0].
//   - Half: wdata={2{sd[15:0]}}, be=addr[1] ? 1100 : 0011.
//   - Word: wdata=sd, be=1111.
// - Load: select the byte or half of dm_rdata by addr[1:0], then sign- or
//   zero-extend to 32 bits.
// - A misaligned access issues no dm_req and no pr_re/pr_we.
//   - Next edge: misalign=1, wb_reg_write=0, wb_out and wb_write_addr updated normally.
// - FSM states:
//   - IDLE: a memory access (read|write, !is_per, !mis) raises dm_req.
//     - dm_ack=1 the same cycle: completes with no stall.
//     - Otherwise: stall=1, go to WAIT.
//   - WAIT: dm_req=1 and stall=1; inputs are held upstream.
//     - On dm_ack: stall=0, result is registered, go to IDLE.
// - While stall=1:
//   - wb_reg_write is written 0, a bubble.
//   - wb_out and wb_write_addr hold, so forwarding to the held instruction stays valid.
// - Peripheral and non-memory instructions complete in one cycle; stall=0.
// - MEM/WB update on a non-stalled edge:
//   - wb_out = mux(ex_mem_to_reg).
//   - wb_write_addr = ex_write_addr.
//   - wb_reg_write = ex_reg_write & !mis.
// - A dm_ack received in IDLE with no request is ignored.
// - Reset asserted during WAIT aborts the access; memory must tolerate a dropped dm_req.
// TESTING
// - sw 0x11223344 @0x100, dm_ack=1 -> dm_be=1111, stall=0; lw @0x100 -> wb_out=0x11223344.
// - lb @0x103 with rdata 0x80FF7F01 -> wb_out=0xFFFFFF80; lbu -> 0x00000080;
//   lh @0x102 -> 0xFFFF80FF.
// - sh 0xBEEF @0x102 -> dm_be=1100, dm_wdata=0xBEEFBEEF; lw @0x101 -> misalign=1,
//   wb_reg_write=0, no dm_req.
// - lw with dm_ack delayed 3 cycles -> stall high 3 cycles, wb_reg_write=0 bubbles,
//   wb_out held, then the load value and wb_reg_write=1.
// - sw @0x40000010 with ex_forward_mem=1, wb_out=0x5A -> pr_we=1, pr_wdata=0x5A,
//   no dm_req; @0x40000018 goes to memory.
// - rst_n low during WAIT -> dm_req, stall and all outputs 0 at once; next access starts from IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with byte/half/word loads and stores.
// Routes each access either to data memory (req/ack handshake) or to a
// single-cycle peripheral window. Owns the MEM/WB register and stalls the
// upstream pipeline while a data-memory access is outstanding.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ex_*                            EX/MEM register contents (held while stall=1)
//   stall                           hold IF..EX/MEM this cycle
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be, dm_rdata/dm_ack   data-memory port
//   pr_re/pr_we/pr_addr/pr_wdata, pr_rdata                 peripheral port
//   wb_out/wb_write_addr/wb_reg_write                      MEM/WB register
//   misalign                        registered one-cycle exception pulse
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no access outstanding; new memory access may complete same cycle
// S_WAIT | data-memory request outstanding, waiting for dm_ack
module mem_stage_lsu #(
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter logic [31:0] PERIPH_SPAN = 32'h0000_0018,
  parameter int          REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_rt_data,
  input  logic [31:0]       ex_pc_plus_4,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_write_addr,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_uns,
  input  logic [1:0]        ex_mem_to_reg,
  input  logic              ex_forward_mem,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              pr_re,
  output logic              pr_we,
  output logic [31:0]       pr_addr,
  output logic [31:0]       pr_wdata,
  input  logic [31:0]       pr_rdata,
  output logic [31:0]       wb_out,
  output logic [REG_AW-1:0] wb_write_addr,
  output logic              wb_reg_write,
  output logic              misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // 33-bit window end so a window touching the top of memory cannot wrap.
  localparam logic [32:0] PER_END = {1'b0, PERIPH_BASE} + {1'b0, PERIPH_SPAN};

  state_t            state_q, state_d;
  logic [31:0]       wb_out_q, wb_out_d;
  logic [REG_AW-1:0] wb_write_addr_q, wb_write_addr_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              misalign_q, misalign_d;

  logic        access, is_per, is_byte, is_half, is_word, mis, mem_acc;
  logic [31:0] store_data, ld_src, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_byte = (ex_mem_size == 2'b00);
    is_half = (ex_mem_size == 2'b01);
    is_word = ex_mem_size[1];
    access  = ex_mem_read | ex_mem_write;
    is_per  = (ex_alu_out >= PERIPH_BASE) && ({1'b0, ex_alu_out} < PER_END);
    mis     = access && ((is_half && ex_alu_out[0]) ||
                         (is_word && (ex_alu_out[1:0] != 2'b00)) ||
                         (is_per && !is_word));
    mem_acc = access && !is_per && !mis;

    store_data = ex_forward_mem ? wb_out_q : ex_rt_data;
    if (is_byte) begin
      dm_wdata = {4{store_data[7:0]}};
      dm_be    = 4'b0001 << ex_alu_out[1:0];
    end else if (is_half) begin
      dm_wdata = {2{store_data[15:0]}};
      dm_be    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
    end else begin
      dm_wdata = store_data;
      dm_be    = 4'b1111;
    end

    ld_src = is_per ? pr_rdata : dm_rdata;
    case (ex_alu_out[1:0])
      2'b00:   ld_byte = ld_src[7:0];
      2'b01:   ld_byte = ld_src[15:8];
      2'b10:   ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    ld_half = ex_alu_out[1] ? ld_src[31:16] : ld_src[15:0];
    if (is_byte)
      load_data = ex_mem_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_data = ex_mem_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else
      load_data = ld_src;
  end

  // Request and strobes are gated by rst_n so they drop the instant reset
  // asserts, even mid-WAIT.
  always_comb begin
    state_d = state_q;
    dm_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_req = mem_acc;
        if (mem_acc && !dm_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        dm_req = 1'b1;
        if (dm_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    dm_req = dm_req & rst_n;
    stall  = dm_req & ~dm_ack;
    dm_we  = dm_req & ex_mem_write;
  end

  assign dm_addr  = {ex_alu_out[31:2], 2'b00};
  assign pr_re    = rst_n & ex_mem_read & is_per & ~mis;
  assign pr_we    = rst_n & ex_mem_write & is_per & ~mis;
  assign pr_addr  = ex_alu_out;
  assign pr_wdata = store_data;

  // While stalled, result/address hold so forwarding to the held
  // instruction sees the previous result; only a bubble is written.
  always_comb begin
    wb_out_d        = wb_out_q;
    wb_write_addr_d = wb_write_addr_q;
    wb_reg_write_d  = 1'b0;
    misalign_d      = 1'b0;
    if (!stall) begin
      if (ex_mem_to_reg[1])      wb_out_d = ex_pc_plus_4;
      else if (ex_mem_to_reg[0]) wb_out_d = load_data;
      else                       wb_out_d = ex_alu_out;
      wb_write_addr_d = ex_write_addr;
      wb_reg_write_d  = ex_reg_write & ~mis;
      misalign_d      = mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wb_out_q        <= '0;
      wb_write_addr_q <= '0;
      wb_reg_write_q  <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wb_out_q        <= wb_out_d;
      wb_write_addr_q <= wb_write_addr_d;
      wb_reg_write_q  <= wb_reg_write_d;
      misalign_q      <= misalign_d;
    end
  end

  assign wb_out        = wb_out_q;
  assign wb_write_addr = wb_write_addr_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: each issued cycle pushes its expected
// combinational and registered response; a monitor pops and compares.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ex_alu_out = '0, ex_rt_data = '0, ex_pc_plus_4 = 32'h1000;
  logic        ex_reg_write = 1'b0;
  logic [4:0]  ex_write_addr = '0;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = 2'b10;
  logic        ex_mem_uns = 1'b0;
  logic [1:0]  ex_mem_to_reg = 2'b00;
  logic        ex_forward_mem = 1'b0;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata = '0;
  logic        dm_ack = 1'b0;
  logic        pr_re, pr_we;
  logic [31:0] pr_addr, pr_wdata;
  logic [31:0] pr_rdata = '0;
  logic [31:0] wb_out;
  logic [4:0]  wb_write_addr;
  logic        wb_reg_write, misalign;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_out(ex_alu_out), .ex_rt_data(ex_rt_data), .ex_pc_plus_4(ex_pc_plus_4),
    .ex_reg_write(ex_reg_write), .ex_write_addr(ex_write_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_uns(ex_mem_uns),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_forward_mem(ex_forward_mem),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .pr_re(pr_re), .pr_we(pr_we), .pr_addr(pr_addr), .pr_wdata(pr_wdata),
    .pr_rdata(pr_rdata), .wb_out(wb_out), .wb_write_addr(wb_write_addr),
    .wb_reg_write(wb_reg_write), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st, rq, we, pre, pwe;
    logic [3:0]  be;
    logic [31:0] wd, wbo;
    logic [4:0]  wa;
    logic        rw, ms;
  } exp_t;

  exp_t q[$];
  logic vld = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: combinational outputs just after the inputs settle, registered
  // outputs just after the following rising edge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (vld) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = q.pop_front();
        chk({e.nm, ".stall"}, {31'h0, stall}, {31'h0, e.st});
        chk({e.nm, ".dm_req"}, {31'h0, dm_req}, {31'h0, e.rq});
        chk({e.nm, ".dm_we"}, {31'h0, dm_we}, {31'h0, e.we});
        chk({e.nm, ".pr_re"}, {31'h0, pr_re}, {31'h0, e.pre});
        chk({e.nm, ".pr_we"}, {31'h0, pr_we}, {31'h0, e.pwe});
        if (e.we) begin
          chk({e.nm, ".dm_be"}, {28'h0, dm_be}, {28'h0, e.be});
          chk({e.nm, ".dm_wdata"}, dm_wdata, e.wd);
          chk({e.nm, ".dm_addr"}, dm_addr, {ex_alu_out[31:2], 2'b00});
        end
        if (e.pwe) chk({e.nm, ".pr_wdata"}, pr_wdata, e.wd);
        @(posedge clk);
        #1;
        chk({e.nm, ".wb_out"}, wb_out, e.wbo);
        chk({e.nm, ".wb_write_addr"}, {27'h0, wb_write_addr}, {27'h0, e.wa});
        chk({e.nm, ".wb_reg_write"}, {31'h0, wb_reg_write}, {31'h0, e.rw});
        chk({e.nm, ".misalign"}, {31'h0, misalign}, {31'h0, e.ms});
      end
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] alu, input logic [31:0] rt, input logic fwd,
                    input logic rw, input logic [4:0] wa, input logic [1:0] m2r,
                    input logic ack, input logic [31:0] rdata, input logic [31:0] prd);
    @(negedge clk);
    ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = sz; ex_mem_uns = uns;
    ex_alu_out = alu; ex_rt_data = rt; ex_forward_mem = fwd;
    ex_reg_write = rw; ex_write_addr = wa; ex_mem_to_reg = m2r;
    dm_ack = ack; dm_rdata = rdata; pr_rdata = prd;
    vld = 1'b1;
  endtask

  task automatic ex(input string nm, input logic st, input logic rq, input logic we,
                    input logic pre, input logic pwe, input logic [3:0] be,
                    input logic [31:0] wd, input logic [31:0] wbo, input logic [4:0] wa,
                    input logic rw, input logic ms);
    exp_t e;
    e.nm = nm; e.st = st; e.rq = rq; e.we = we; e.pre = pre; e.pwe = pwe;
    e.be = be; e.wd = wd; e.wbo = wbo; e.wa = wa; e.rw = rw; e.ms = ms;
    q.push_back(e);
  endtask

  task automatic nop_inputs();
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    dm_ack = 1'b0; ex_forward_mem = 1'b0; ex_mem_to_reg = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a memory load presented: nothing may be requested.
    ex_mem_read = 1'b1; ex_alu_out = 32'h100; ex_mem_size = 2'b10;
    #12;
    chk("rst.dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst.stall", {31'h0, stall}, 32'h0);
    chk("rst.wb_out", wb_out, 32'h0);
    chk("rst.wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    chk("rst.misalign", {31'h0, misalign}, 32'h0);
    nop_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    //  rd wr sz  uns alu           rt            fwd rw wa  m2r   ack rdata         prd
    op(0, 1, 2'b10, 0, 32'h100, 32'h11223344, 0, 0, 5'd0, 2'b00, 1, 32'h0, 32'h0);
    ex("sw", 0, 1, 1, 0, 0, 4'b1111, 32'h11223344, 32'h100, 5'd0, 0, 0);
    op(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 1, 5'd5, 2'b01, 1, 32'h11223344, 32'h0);
    ex("lw", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h11223344, 5'd5, 1, 0);
    op(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 1, 5'd6, 2'b01, 1, 32'h80FF7F01, 32'h0);
    ex("lb", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80, 5'd6, 1, 0);
    op(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 1, 5'd7, 2'b01, 1, 32'h80FF7F01, 32'h0);
    ex("lbu", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h00000080, 5'd7, 1, 0);
    op(1, 0, 2'b01, 0, 32'h102, 32'h0, 0, 1, 5'd8, 2'b01, 1, 32'h80FF7F01, 32'h0);
    ex("lh", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF80FF, 5'd8, 1, 0);
    op(0, 1, 2'b01, 0, 32'h102, 32'h0000BEEF, 0, 0, 5'd9, 2'b00, 1, 32'h0, 32'h0);
    ex("sh", 0, 1, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'h102, 5'd9, 0, 0);
    op(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 1, 5'd10, 2'b01, 0, 32'hDEADBEEF, 32'h0);
    ex("lw_mis", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'hDEADBEEF, 5'd10, 0, 1);
    op(0, 0, 2'b10, 0, 32'h1234, 32'h0, 0, 1, 5'd11, 2'b00, 0, 32'h0, 32'h0);
    ex("alu", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h1234, 5'd11, 1, 0);
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 2'b10, 0, 32'h200, 32'h0, 0, 1, 5'd12, 2'b01, 0, 32'h0, 32'h0);
      ex("lw_wait", 1, 1, 0, 0, 0, 4'h0, 32'h0, 32'h1234, 5'd11, 0, 0);
    end
    op(1, 0, 2'b10, 0, 32'h200, 32'h0, 0, 1, 5'd12, 2'b01, 1, 32'hCAFEF00D, 32'h0);
    ex("lw_ack", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'hCAFEF00D, 5'd12, 1, 0);
    op(0, 0, 2'b10, 0, 32'h5A, 32'h0, 0, 1, 5'd1, 2'b00, 0, 32'h0, 32'h0);
    ex("alu_5a", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h5A, 5'd1, 1, 0);
    op(0, 1, 2'b10, 0, 32'h40000010, 32'hFFFFFFFF, 1, 0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
    ex("sw_per_fwd", 0, 0, 0, 0, 1, 4'h0, 32'h5A, 32'h40000010, 5'd0, 0, 0);
    op(0, 1, 2'b10, 0, 32'h40000018, 32'h77, 0, 0, 5'd0, 2'b00, 1, 32'h0, 32'h0);
    ex("sw_per_end", 0, 1, 1, 0, 0, 4'b1111, 32'h77, 32'h40000018, 5'd0, 0, 0);
    op(1, 0, 2'b10, 0, 32'h40000004, 32'h0, 0, 1, 5'd2, 2'b01, 0, 32'h0, 32'h600DD00D);
    ex("lw_per", 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h600DD00D, 5'd2, 1, 0);
    op(1, 0, 2'b10, 0, 32'h40000014, 32'h0, 0, 1, 5'd3, 2'b01, 0, 32'h0, 32'h0BADCAFE);
    ex("lw_per_last", 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0BADCAFE, 5'd3, 1, 0);
    op(1, 0, 2'b10, 0, 32'h3FFFFFFC, 32'h0, 0, 1, 5'd13, 2'b01, 1, 32'h13579BDF, 32'h0);
    ex("lw_below_per", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h13579BDF, 5'd13, 1, 0);
    op(1, 0, 2'b00, 0, 32'h40000004, 32'h0, 0, 1, 5'd3, 2'b00, 0, 32'h0, 32'h0);
    ex("lb_per_mis", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h40000004, 5'd3, 0, 1);
    op(0, 1, 2'b00, 0, 32'h101, 32'h000000AB, 0, 0, 5'd0, 2'b00, 1, 32'h0, 32'h0);
    ex("sb", 0, 1, 1, 0, 0, 4'b0010, 32'hABABABAB, 32'h101, 5'd0, 0, 0);
    ex_pc_plus_4 = 32'h404;
    op(0, 0, 2'b10, 0, 32'h55, 32'h0, 0, 1, 5'd31, 2'b10, 0, 32'h0, 32'h0);
    ex("link", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h404, 5'd31, 1, 0);
    op(0, 0, 2'b10, 0, 32'h77, 32'h0, 0, 1, 5'd4, 2'b00, 1, 32'h0, 32'h0);
    ex("idle_ack", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h77, 5'd4, 1, 0);
    op(1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 1, 5'd14, 2'b01, 0, 32'h0, 32'h0);
    ex("lw_pre_rst", 1, 1, 0, 0, 0, 4'h0, 32'h0, 32'h77, 5'd4, 0, 0);

    // Reset while WAIT, with the load still presented.
    @(negedge clk);
    vld = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_wait.dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst_wait.stall", {31'h0, stall}, 32'h0);
    chk("rst_wait.wb_out", wb_out, 32'h0);
    chk("rst_wait.wb_write_addr", {27'h0, wb_write_addr}, 32'h0);
    chk("rst_wait.wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    nop_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 0, 2'b10, 0, 32'h99, 32'h0, 0, 1, 5'd15, 2'b00, 0, 32'h0, 32'h0);
    ex("post_rst_idle", 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h99, 5'd15, 1, 0);
    op(1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 1, 5'd14, 2'b01, 1, 32'h2468ACE0, 32'h0);
    ex("post_rst_lw", 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h2468ACE0, 5'd14, 1, 0);

    @(negedge clk);
    vld = 1'b0;
    nop_inputs();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
